// File: rtl/ahb_slave_mem.sv
`timescale 1ns/1ps
// ahb_slave_mem
//   AHB slave responder backed by a word-organised memory. It decodes the
//   address phase, inserts WAIT_STATES hready-low cycles per OKAY transfer,
//   writes only the addressed byte lanes (little-endian) and returns
//   registered read data. Illegal transfers get the two-cycle ERROR response
//   and never touch memory.
//
// Parameters
//   AW          address width in bits
//   DW          data width in bits (32 only)
//   DEPTH       number of DW-bit memory words
//   WAIT_STATES hready-low cycles per OKAY data phase (0..15)
//
// Ports
//   HCLK     bus clock, rising edge
//   HRESET   asynchronous active-high reset
//   hselect  slave select (address phase)
//   htrans   IDLE/BUSY/NONSEQ/SEQ
//   haddr    byte address
//   hwrite   1 write, 0 read
//   hsize    transfer size, 2^hsize bytes
//   hburst   burst type, unused (every beat carries its own address)
//   hwdata   write data (data phase)
//   hready   transfer done / slave ready
//   hresp    00 OKAY, 01 ERROR
//   hrdata   read data, valid when hready=1 in a read data phase
module ahb_slave_mem #(
  parameter int AW          = 16,
  parameter int DW          = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          hselect,
  input  logic [1:0]    htrans,
  input  logic [AW-1:0] haddr,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [2:0]    hburst,
  input  logic [DW-1:0] hwdata,
  output logic          hready,
  output logic [1:0]    hresp,
  output logic [DW-1:0] hrdata
);

  localparam int NL = DW / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q;
  logic            dp_valid_q;
  logic            dp_write_q;
  logic [IW-1:0]   dp_idx_q;
  logic [NL-1:0]   dp_lanes_q;

  logic [DW-1:0]   mem [DEPTH];

  logic            sample;
  logic            size_ok;
  logic            in_range;
  logic            legal;
  logic [IW-1:0]   addr_idx;
  logic [NL-1:0]   addr_lanes;
  logic            complete;
  logic            commit;
  logic            load_rd;
  logic [IW-1:0]   load_idx;
  logic            fwd;
  logic [DW-1:0]   rd_word;

  // Burst type and the SEQ/NONSEQ distinction do not affect this slave.
  logic unused_ok;
  assign unused_ok = ^{htrans[0], hburst};

  // Outputs are a pure decode of the state register.
  assign hready = (state_q == S_IDLE) || (state_q == S_ERR2);
  assign hresp  = {1'b0, (state_q == S_ERR1) || (state_q == S_ERR2)};

  // Address-phase decode.
  assign sample   = hready && hselect && htrans[1];
  assign addr_idx = haddr[IW+1:2];
  assign in_range = (int'(haddr[AW-1:2]) < DEPTH);
  assign legal    = size_ok && in_range;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    size_ok    = 1'b0;
    addr_lanes = '0;
    case (hsize)
      3'd0: begin
        size_ok    = 1'b1;
        addr_lanes = 4'b0001 << haddr[1:0];
      end
      3'd1: begin
        size_ok    = ~haddr[0];
        addr_lanes = 4'b0011 << haddr[1:0];
      end
      3'd2: begin
        size_ok    = (haddr[1:0] == 2'b00);
        addr_lanes = 4'b1111;
      end
      default: begin
        size_ok    = 1'b0;
        addr_lanes = '0;
      end
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_ERR2: begin
        state_d = S_IDLE;
        if (sample) begin
          if (!legal)                state_d = S_ERR1;
          else if (WAIT_STATES > 0)  state_d = S_WAIT;
          else                       state_d = S_IDLE;
        end
      end
      S_WAIT:  if (cnt_q <= 4'd1) state_d = S_IDLE;
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  // A data phase completes in the IDLE state (hready=1, hresp=OKAY) while a
  // legal transfer is pending; ERR states never hold a valid data phase.
  assign complete = (state_q == S_IDLE) && dp_valid_q;
  assign commit   = complete && dp_write_q;

  // hrdata is loaded on the edge that enters the completing data phase: the
  // sampling edge itself with no wait states, else the last WAIT edge.
  always_comb begin
    load_rd  = 1'b0;
    load_idx = dp_idx_q;
    if (WAIT_STATES == 0) begin
      load_rd  = sample && legal && !hwrite;
      load_idx = addr_idx;
    end else begin
      load_rd  = (state_q == S_WAIT) && (cnt_q == 4'd1) && !dp_write_q;
    end
  end

  // A write finishing on the same edge as a read load to the same word has
  // not reached the array yet, so its lanes are merged in here.
  assign fwd = commit && load_rd && (load_idx == dp_idx_q);

  always_comb begin
    rd_word = mem[load_idx];
    for (int i = 0; i < NL; i++) begin
      if (fwd && dp_lanes_q[i]) rd_word[8*i +: 8] = hwdata[8*i +: 8];
    end
  end

  // Control state. A reset mid-transfer clears dp_valid_q, so a pending
  // write is dropped.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_idx_q   <= '0;
      dp_lanes_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_WAIT) cnt_q <= cnt_q - 4'd1;
      if (sample) begin
        dp_valid_q <= legal;
        dp_write_q <= hwrite;
        dp_idx_q   <= addr_idx;
        dp_lanes_q <= addr_lanes;
        if (legal) cnt_q <= 4'(WAIT_STATES);
      end else if (complete) begin
        dp_valid_q <= 1'b0;
      end
    end
  end

  // NOTE: the memory array has no reset; clearing it would need a port per
  // word. Writes are gated by commit, which is low while HRESET is high.
  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int i = 0; i < NL; i++) begin
        if (dp_lanes_q[i]) mem[dp_idx_q][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  // Registered read data; holds between reads.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)       hrdata <= '0;
    else if (load_rd) hrdata <= rd_word;
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
`timescale 1ns/1ps
// Testbench for ahb_slave_mem. Two instances share the bus inputs (separate
// selects): u_dut0 with no wait states, u_dut1 with three. Expected
// responses, wait counts and read data come from a byte-addressed model.
module tb_ahb_slave_mem;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        sel0, sel1;
  logic [1:0]  htrans;
  logic [15:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready0, hready1;
  logic [1:0]  hresp0, hresp1;
  logic [31:0] hrdata0, hrdata1;

  int n_checks = 0;
  int n_errors = 0;

  // kind: 0 transfer, 1 IDLE, 2 BUSY, 3 NONSEQ with hselect low
  typedef struct {
    int          kind;
    bit          wr;
    logic [15:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t       seq[$];
  logic [7:0]  ref_mem [2][1024];
  logic [31:0] last_rdata;

  always #5 HCLK = ~HCLK;

  ahb_slave_mem #(.AW(16), .DW(32), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .hselect(sel0), .htrans(htrans),
    .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hwdata(hwdata), .hready(hready0), .hresp(hresp0), .hrdata(hrdata0)
  );

  ahb_slave_mem #(.AW(16), .DW(32), .DEPTH(256), .WAIT_STATES(3)) u_dut1 (
    .HCLK(HCLK), .HRESET(HRESET), .hselect(sel1), .htrans(htrans),
    .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hwdata(hwdata), .hready(hready1), .hresp(hresp1), .hrdata(hrdata1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit ref_legal(input logic [15:0] a, input logic [2:0] s);
    int bytes;
    if (s > 3'd2) return 1'b0;
    bytes = 1 << s;
    if ((int'(a) % bytes) != 0) return 1'b0;
    return int'(a) < 1024;
  endfunction

  function automatic logic [31:0] ref_word(input int d, input logic [15:0] a);
    logic [31:0] w;
    int base;
    base = (int'(a) / 4) * 4;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = ref_mem[d][base + b];
    return w;
  endfunction

  task automatic ref_write(input int d, input xfer_t x);
    int a;
    for (int b = 0; b < (1 << x.size); b++) begin
      a = int'(x.addr) + b;
      ref_mem[d][a] = x.wdata[8*(a % 4) +: 8];
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic xfer_t mk(input bit wr, input logic [15:0] a,
                               input logic [2:0] s, input logic [31:0] wd);
    xfer_t x;
    x.kind = 0; x.wr = wr; x.addr = a; x.size = s; x.wdata = wd;
    return x;
  endfunction

  function automatic xfer_t rand_xfer();
    xfer_t x;
    int r;
    r = $urandom_range(0, 99);
    x.kind  = (r < 10) ? 1 : (r < 15) ? 2 : (r < 20) ? 3 : 0;
    x.wr    = 1'($urandom_range(0, 1));
    x.wdata = $urandom();
    x.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    x.addr  = 16'($urandom_range(0, 1023));
    if ($urandom_range(0, 4) != 0 && x.size <= 3'd2)
      x.addr = x.addr & ~((16'd1 << x.size) - 16'd1);
    if ($urandom_range(0, 19) == 0) x.addr = 16'($urandom_range(1024, 65535));
    return x;
  endfunction

  task automatic drive_idle();
    sel0 = 1'b0; sel1 = 1'b0; htrans = 2'b00;
  endtask

  task automatic drive_addr(input int d, input xfer_t x);
    logic s;
    s = 1'b1;
    case (x.kind)
      0:       htrans = {1'b1, 1'($urandom_range(0, 1))};
      1:       htrans = 2'b00;
      2:       htrans = 2'b01;
      default: begin htrans = 2'b10; s = 1'b0; end
    endcase
    sel0   = (d == 0) ? s : 1'b0;
    sel1   = (d == 1) ? s : 1'b0;
    haddr  = x.addr;
    hwrite = x.wr;
    hsize  = x.size;
    hburst = 3'($urandom_range(0, 7));
  endtask

  // Runs the queued items back to back on DUT d: the address phase of item
  // i overlaps the data phase of item i-1. Outputs are sampled on negedges.
  task automatic run_seq(input int d);
    int          n, waits, exp_waits;
    logic [1:0]  resp, exp_resp;
    logic [31:0] rdata;
    bit          lg;
    xfer_t       p;
    n = seq.size();
    for (int i = 0; i <= n; i++) begin
      if (i < n) drive_addr(d, seq[i]); else drive_idle();
      hwdata    = (i > 0) ? seq[i-1].wdata : 32'h0;
      lg        = 1'b0;
      exp_resp  = 2'b00;
      exp_waits = 0;
      if (i > 0) begin
        p         = seq[i-1];
        lg        = (p.kind == 0) && ref_legal(p.addr, p.size);
        exp_resp  = (p.kind == 0 && !lg) ? 2'b01 : 2'b00;
        exp_waits = (p.kind != 0) ? 0 : (!lg ? 1 : (d == 1 ? 3 : 0));
      end
      waits = 0;
      forever begin
        @(negedge HCLK);
        resp = (d == 1) ? hresp1 : hresp0;
        if ((d == 1) ? hready1 : hready0) break;
        if (i > 0) check("resp_wait", 32'(resp), 32'(exp_resp));
        waits++;
        if (waits > 40) begin
          n_checks++; n_errors++;
          $display("FAIL hready_timeout: hready low for %0d cycles, expected at most %0d", waits, exp_waits);
          break;
        end
      end
      rdata = (d == 1) ? hrdata1 : hrdata0;
      if (i > 0) begin
        check("waits", 32'(waits), 32'(exp_waits));
        check("resp", 32'(resp), 32'(exp_resp));
        if (lg && !p.wr) begin
          check("rdata", rdata, ref_word(d, p.addr));
          last_rdata = rdata;
        end
        if (lg && p.wr) ref_write(d, p);
      end
      @(posedge HCLK); #1;
    end
    seq.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    HRESET = 1'b1;
    drive_idle();
    haddr = '0; hwrite = 1'b0; hsize = 3'd2; hburst = '0; hwdata = '0;
    last_rdata = '0;
    #2;
    check("reset_hready0", 32'(hready0), 32'd1);
    check("reset_hresp0", 32'(hresp0), 32'd0);
    check("reset_hrdata0", hrdata0, 32'h0);
    check("reset_hready1", 32'(hready1), 32'd1);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    // Known contents everywhere (memory is not reset).
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 256; w++) seq.push_back(mk(1'b1, 16'(w * 4), 3'd2, $urandom()));
      run_seq(d);
    end

    // IDLE / BUSY / unselected traffic: zero-wait OKAY, memory untouched.
    for (int k = 0; k < 6; k++) begin
      xfer_t x;
      x = mk(1'b1, 16'h0010, 3'd2, 32'hFFFF_FFFF);
      x.kind = 1 + (k % 3);
      seq.push_back(x);
    end
    seq.push_back(mk(1'b0, 16'h0010, 3'd2, 32'h0));
    run_seq(0);

    // Pipelined write then read of the same word (forwarding path).
    seq.push_back(mk(1'b1, 16'h0010, 3'd2, 32'hDEAD_BEEF));
    seq.push_back(mk(1'b0, 16'h0010, 3'd2, 32'h0));
    run_seq(0);
    check("pipe_rdata", last_rdata, 32'hDEAD_BEEF);

    // Byte lanes.
    seq.push_back(mk(1'b1, 16'h0020, 3'd2, 32'h1122_3344));
    seq.push_back(mk(1'b1, 16'h0022, 3'd0, 32'hAAAA_AAAA));
    seq.push_back(mk(1'b1, 16'h0020, 3'd1, 32'hBBBB_BBBB));
    seq.push_back(mk(1'b0, 16'h0020, 3'd2, 32'h0));
    run_seq(0);
    check("lanes_rdata", last_rdata, 32'h11AA_BBBB);

    // Wait states: read and write on the 3-wait instance.
    seq.push_back(mk(1'b1, 16'h0040, 3'd2, 32'h0BAD_CAFE));
    seq.push_back(mk(1'b0, 16'h0040, 3'd2, 32'h0));
    run_seq(1);
    check("ws3_rdata", last_rdata, 32'h0BAD_CAFE);

    // Errors followed by a NONSEQ sampled in ERR2, on both instances.
    for (int d = 0; d < 2; d++) begin
      seq.push_back(mk(1'b1, 16'h0002, 3'd2, 32'hFFFF_FFFF));
      seq.push_back(mk(1'b0, 16'h0000, 3'd2, 32'h0));
      seq.push_back(mk(1'b1, 16'h0040, 3'd3, 32'hFFFF_FFFF));
      seq.push_back(mk(1'b0, 16'h0040, 3'd2, 32'h0));
      seq.push_back(mk(1'b1, 16'h0400, 3'd2, 32'hFFFF_FFFF));
      seq.push_back(mk(1'b0, 16'h0000, 3'd2, 32'h0));
      seq.push_back(mk(1'b1, 16'h0021, 3'd1, 32'hFFFF_FFFF));
      seq.push_back(mk(1'b0, 16'h0020, 3'd2, 32'h0));
      run_seq(d);
    end

    // Randomized traffic.
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 250; k++) seq.push_back(rand_xfer());
      run_seq(d);
    end

    // Reset during the WAIT of a write: the write is dropped.
    seq.push_back(mk(1'b1, 16'h0084, 3'd2, 32'h1234_5678));
    seq.push_back(mk(1'b0, 16'h0084, 3'd2, 32'h0));
    run_seq(1);
    sel0 = 1'b0; sel1 = 1'b1; htrans = 2'b10; hwrite = 1'b1;
    haddr = 16'h0080; hsize = 3'd2;
    @(posedge HCLK); #1;
    drive_idle();
    hwdata = 32'hCAFE_F00D;
    @(negedge HCLK);
    check("rst_pre_wait", 32'(hready1), 32'd0);
    #2 HRESET = 1'b1;
    #1;
    check("rst_hready1", 32'(hready1), 32'd1);
    check("rst_hresp1", 32'(hresp1), 32'd0);
    check("rst_hrdata1", hrdata1, 32'h0);
    check("rst_hrdata0", hrdata0, 32'h0);
    @(posedge HCLK); #1;
    check("rst_hold_ready", 32'(hready1), 32'd1);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    seq.push_back(mk(1'b0, 16'h0080, 3'd2, 32'h0));
    run_seq(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
AHB slave responder backed by a word-organised memory array, acting as the slave end of the team's AHB interface. It decodes address-phase controls, inserts a configurable number of wait states and performs byte-lane writes and registered reads. It issues the two-cycle ERROR response for illegal transfers. It is the DUT-side counterpart the master driver and monitor are verified against.

Parameters:
AW, 16, address width in bits
DW, 32, data width in bits (32 only in this version)
DEPTH, 256, number of DW-bit memory words
WAIT_STATES, 0, hready-low cycles inserted per OKAY data phase (0..15)

Ports:
HCLK  input  1  bus clock; all state changes on rising edge
HRESET  input  1  asynchronous active-high reset
hselect  input  1  slave select, valid in address phase
htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
haddr  input  AW  byte address
hwrite  input  1  1 write, 0 read
hsize  input  3  transfer size, 2^hsize bytes
hburst  input  3  burst type; ignored, every beat carries its own address
hwdata  input  DW  write data, valid in data phase
hready  output  1  transfer-complete / slave-ready
hresp  output  2  00 OKAY, 01 ERROR
hrdata  output  DW  read data, valid when hready=1 in a read data phase

Behaviour:
- Reset values (async on HRESET=1): hready=1, hresp=00, hrdata=0, FSM=IDLE, wait counter=0. Memory contents are not reset.
- Reset mid-transfer aborts the transfer. A pending write is discarded.
- Address-phase sample: on a rising edge with hready=1, hselect=1 and htrans[1]=1. Latch haddr, hwrite and hsize.
- IDLE, BUSY or hselect=0: zero-wait OKAY response; nothing latched.
- Legality: hsize<=2.
  - hsize=1 requires haddr[0]=0.
  - hsize=2 requires haddr[1:0]=0.
  - Word index haddr[AW-1:2] must be < DEPTH.
- Byte lanes (little-endian): lanes = ((1<<(1<<hsize))-1) << haddr[1:0].
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: hready=1, hresp=00.
    - Legal sample with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES.
    - Legal sample with WAIT_STATES=0 -> stay IDLE; the next cycle is the completing data phase.
    - Illegal sample -> ERR1.
  - WAIT: hready=0, hresp=00, counter decrements each cycle. At 1 -> IDLE, and that next cycle completes with hready=1. Address-phase inputs are ignored while hready=0.
  - ERR1: hready=0, hresp=01 -> ERR2.
  - ERR2: hready=1, hresp=01. A new address phase may be sampled this edge, with the same rules as IDLE.
- Write commit: on the edge ending the completing data phase (hready=1, hresp=00), only the enabled lanes of hwdata are written to mem[index]. Errored writes never modify memory.
- Read: hrdata is registered.
  - It loads mem[index] on the edge entering the completing data phase.
  - It holds its value otherwise.
  - It is not cleared on non-read cycles.
- Read-after-write forwarding: a write completing on the same edge a read to the same word loads hrdata must be forwarded. hrdata takes new bytes on written lanes and old bytes elsewhere.
- Back-to-back pipelined transfers with WAIT_STATES=0 run at one beat per cycle with no bubbles.
- hresp[1] is always 0 (no RETRY/SPLIT).

Test Plan:
- Reset then IDLE traffic: assert HRESET mid-cycle -> hready=1, hresp=00, hrdata=0 immediately. Stream of htrans=00 -> hready stays 1, no memory change.
- WAIT_STATES=0 pipeline: NONSEQ write 0xDEADBEEF @0x0010, then read @0x0010 in the next address phase -> no hready low. Read data phase returns 0xDEADBEEF (forwarded).
- Byte lanes: word write 0x11223344 @0x20, byte write 0xAA..AA hsize=0 @0x22, halfword write 0xBBBB hsize=1 @0x20 -> word read @0x20 returns 0x11AABBBB.
- WAIT_STATES=3: read @0x0040 -> exactly 3 cycles hready=0/hresp=00, then hready=1 with correct data. Write is committed only on the completing edge.
- Errors: each of the following -> ERR1 (hready=0, hresp=01), then ERR2 (hready=1, hresp=01); target word unchanged.
  - Word access @0x0002.
  - hsize=3.
  - Address with word index 256 (@0x0400).
  - A NONSEQ sampled in ERR2 completes OKAY.
- Reset during WAIT of a write @0x0080 (WAIT_STATES=3) -> after reset, read @0x0080 returns the prior contents; hready=1 during reset.
